mod_n_cascade_counter: RTL

Parametrised multi-digit modulo-N counter. It generalises the team's fixed mod-6 JK-style counter to any modulus, any digit count, up/down mode, parallel load and cascade carry. Each digit counts 0..MOD-1, and carries ripple combinationally through the digits within a single clock. The block serves as the timebase/sequence counter in the counter subsystem, and multiple instances chain through cin/tc.

---
 rtl/mod_n_cascade_counter_pkg.sv | 22 ++
 rtl/mod_n_cascade_counter_digit.sv | 49 ++++
 rtl/mod_n_cascade_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared definitions for the cascaded modulo-N counter: digit width and
// parameter legality helpers.
package mod_cnt_pkg;

  localparam int MOD_MIN    = 2;
  localparam int MOD_MAX    = 256;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic int digit_w(input int mod);
    return $clog2(mod);
  endfunction

  function automatic bit mod_ok(input int mod);
    return (mod >= MOD_MIN) && (mod <= MOD_MAX);
  endfunction

  function automatic bit digits_ok(input int digits);
    return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX);
  endfunction

endpackage

// File: rtl/mod_n_cascade_counter_digit.sv
// One modulo-MOD digit: clear / load / step up or down, with end-of-range flags
// used by the ripple chain.
module mod_n_digit #(
  parameter int MOD = 6,
  parameter int W   = mod_cnt_pkg::digit_w(MOD)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sync_clr,
  input  logic         step,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic         at_max,
  output logic         at_zero,
  output logic         ld_bad
);

  localparam logic [W:0]   MODV = (W+1)'(MOD);
  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] val_q, val_d;

  assign ld_bad  = ({1'b0, ld_val} >= MODV);
  assign at_max  = (val_q == MAXV);
  assign at_zero = (val_q == '0);
  assign val     = val_q;

  // Out-of-range values (only reachable via corruption) fold back on the next step.
  always_comb begin
    val_d = val_q;
    if (sync_clr)
      val_d = '0;
    else if (load)
      val_d = ld_bad ? '0 : ld_val;
    else if (step) begin
      if (up_dn)
        val_d = (val_q >= MAXV) ? '0 : val_q + W'(1);
      else
        val_d = (val_q == '0 || val_q > MAXV) ? MAXV : val_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) val_q <= '0;
    else          val_q <= val_d;

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Multi-digit modulo-MOD up/down counter with parallel load, combinational
// cascade carry (tc) and a registered full-range wrap pulse.
module mod_n_cascade_counter
  import mod_cnt_pkg::*;
#(
  parameter int MOD    = 6,
  parameter int DIGITS = 2,
  parameter int W      = digit_w(MOD)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sync_clr,
  input  logic                en,
  input  logic                cin,
  input  logic                up_dn,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  if (!mod_ok(MOD)) begin : g_bad_mod
    $error("mod_n_cascade_counter: MOD out of range 2..256");
  end
  if (!digits_ok(DIGITS)) begin : g_bad_digits
    $error("mod_n_cascade_counter: DIGITS out of range 1..8");
  end

  logic [DIGITS-1:0][W-1:0] ld_v, cnt;
  logic [DIGITS-1:0]        at_max, at_zero, ld_bad;
  logic [DIGITS:0]          step_c;
  logic                     step;
  logic                     wrap_q, wrap_d, err_q, err_d;

  assign step      = en & cin;
  assign step_c[0] = step;
  assign ld_v      = load_val;

  // Ripple enable: digit i+1 steps only when every lower digit is at its end value.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign step_c[i+1] = step_c[i] & (up_dn ? at_max[i] : at_zero[i]);

    mod_n_digit #(.MOD(MOD), .W(W)) u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_clr(sync_clr),
      .step    (step_c[i]),
      .up_dn   (up_dn),
      .load    (load),
      .ld_val  (ld_v[i]),
      .val     (cnt[i]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i]),
      .ld_bad  (ld_bad[i])
    );
  end

  assign count = cnt;
  assign tc    = step_c[DIGITS];

  always_comb begin
    wrap_d = 1'b0;
    err_d  = err_q;
    if (sync_clr)
      err_d = 1'b0;
    else if (load)
      err_d = err_q | (|ld_bad);
    else if (step)
      wrap_d = tc;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end

  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule
